usbf_mem_req_arb: RTL and testbench



---
 rtl/usbf_mem_req_arb_pkg.sv | 28 ++
 rtl/usbf_rr_arb.sv | 50 +++++
 rtl/usbf_mem_req_arb.sv | 198 +++++++++++++++++++
 tb/tb_usbf_mem_req_arb.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usbf_mem_req_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usbf_mem_req_arb_pkg
// Description : Shared definitions for the hclk-domain memory request
//               arbiter: endpoint count and data width taken from the core
//               configuration, the default access watchdog, and the
//               scheduler state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package usbf_mem_req_arb_pkg;

  // Core configuration (mirrors usbf_cfg_defs)
  localparam int USB_EP_NUM          = 4;
  localparam int USB_EP0_DATA_DATA_W = 32;

  // Default watchdog: WAIT-state cycles before an access is abandoned
  localparam int MEM_ARB_TIMEOUT = 200;
  localparam int MEM_ARB_TO_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage : usbf_mem_req_arb_pkg
`default_nettype wire

// File: rtl/usbf_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : usbf_rr_arb
// Description : Combinational N-way round-robin arbiter. The search starts
//               at the pointer position and wraps modulo N; the first set
//               request bit found wins.
// Ports       : req_i   - request vector
//               ptr_i   - search start index (must be < N)
//               grant_o - one-hot grant
//               idx_o   - encoded index of the grant
//               any_o   - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module usbf_rr_arb
  import usbf_mem_req_arb_pkg::*;
#(
  parameter int N     = USB_EP_NUM,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    int   cand;
    logic found;
    grant_o = '0;
    idx_o   = '0;
    cand    = 0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      // Candidate position (ptr + k) mod N without a divider
      cand = int'(ptr_i) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!found && req_i[IDX_W'(cand)]) begin
        found                   = 1'b1;
        grant_o[IDX_W'(cand)]   = 1'b1;
        idx_o                   = IDX_W'(cand);
      end
    end
    any_o = found;
  end

endmodule : usbf_rr_arb
`default_nettype wire

// File: rtl/usbf_mem_req_arb.sv
`default_nettype none
// ============================================================================
// Module      : usbf_mem_req_arb
// Description : hclk-domain scheduler sharing the single outstanding CDC
//               memory-access slot between per-endpoint FIFO write and read
//               requesters. Issues a one-hot data request pulse, holds the
//               TX word while the request crosses, waits for the matching
//               ready pulse (or the watchdog), then acks the requester.
// Ports       : hclk_i, rst_i          - clock, synchronous active-high reset
//               req_wt_i / req_rd_i    - level requests per EP, held to ack
//               req_wdata_i            - write word per EP
//               ack_o / ack_err_o      - completion pulse and timeout flag
//               rdata_o                - last completed read word
//               ep_data_wt_req_o/rd    - one-hot pulses to the synchronizer
//               ep_tx_data_o           - registered TX word per EP
//               ep_rx_data_i           - RX words from the synchronizer
//               mem_wt_ready_i/rd      - completion pulses (hclk domain)
//               busy_o                 - scheduler not idle
// Revision    : 1.0 - initial release
// ============================================================================
module usbf_mem_req_arb
  import usbf_mem_req_arb_pkg::*;
#(
  parameter int EP_NUM  = USB_EP_NUM,
  parameter int DATA_W  = USB_EP0_DATA_DATA_W,
  parameter int TIMEOUT = MEM_ARB_TIMEOUT,
  parameter int TO_W    = MEM_ARB_TO_W
) (
  input  logic                     hclk_i,
  input  logic                     rst_i,
  input  logic [EP_NUM-1:0]        req_wt_i,
  input  logic [EP_NUM-1:0]        req_rd_i,
  input  logic [DATA_W*EP_NUM-1:0] req_wdata_i,
  output logic [EP_NUM-1:0]        ack_o,
  output logic                     ack_err_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic [EP_NUM-1:0]        ep_data_wt_req_o,
  output logic [EP_NUM-1:0]        ep_data_rd_req_o,
  output logic [DATA_W*EP_NUM-1:0] ep_tx_data_o,
  input  logic [DATA_W*EP_NUM-1:0] ep_rx_data_i,
  input  logic                     mem_wt_ready_i,
  input  logic                     mem_rd_ready_i,
  output logic                     busy_o
);

  localparam int IDX_W = (EP_NUM > 1) ? $clog2(EP_NUM) : 1;

  // Per-EP views of the packed data buses
  logic [DATA_W-1:0] w_wdata   [EP_NUM];
  logic [DATA_W-1:0] w_rx_data [EP_NUM];

  arb_state_e         state_q,   state_d;
  logic [IDX_W-1:0]   ptr_q,     ptr_d;
  logic [EP_NUM-1:0]  grant_q,   grant_d;
  logic [IDX_W-1:0]   idx_q,     idx_d;
  logic               dir_wt_q,  dir_wt_d;
  logic [TO_W-1:0]    cnt_q,     cnt_d;
  logic [EP_NUM-1:0]  ack_q,     ack_d;
  logic               ack_err_q, ack_err_d;
  logic [DATA_W-1:0]  rdata_q,   rdata_d;
  logic [EP_NUM-1:0]  wt_req_q,  wt_req_d;
  logic [EP_NUM-1:0]  rd_req_q,  rd_req_d;
  logic               busy_q,    busy_d;
  logic [DATA_W-1:0]  tx_data_q [EP_NUM];
  logic [DATA_W-1:0]  tx_data_d [EP_NUM];

  logic [EP_NUM-1:0]  w_arb_req;
  logic [EP_NUM-1:0]  w_arb_grant;
  logic [IDX_W-1:0]   w_arb_idx;
  logic               w_arb_any;
  logic               w_ready_hit;

  for (genvar e = 0; e < EP_NUM; e++) begin : g_ep_slice
    assign w_wdata[e]                          = req_wdata_i[e*DATA_W +: DATA_W];
    assign w_rx_data[e]                        = ep_rx_data_i[e*DATA_W +: DATA_W];
    assign ep_tx_data_o[e*DATA_W +: DATA_W]    = tx_data_q[e];
  end

  // An EP competes if it wants either direction; write wins inside an EP
  assign w_arb_req = req_wt_i | req_rd_i;

  usbf_rr_arb #(
    .N     (EP_NUM),
    .IDX_W (IDX_W)
  ) u_rr_arb (
    .req_i   (w_arb_req),
    .ptr_i   (ptr_q),
    .grant_o (w_arb_grant),
    .idx_o   (w_arb_idx),
    .any_o   (w_arb_any)
  );

  // Only the ready pulse of the granted direction completes the access
  assign w_ready_hit = dir_wt_q ? mem_wt_ready_i : mem_rd_ready_i;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    dir_wt_d  = dir_wt_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    ack_err_d = 1'b0;
    rdata_d   = rdata_q;
    wt_req_d  = '0;
    rd_req_d  = '0;
    tx_data_d = tx_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (w_arb_any) begin
          state_d  = ST_ISSUE;
          grant_d  = w_arb_grant;
          idx_d    = w_arb_idx;
          dir_wt_d = |(req_wt_i & w_arb_grant);
          // Pulses are registered so they appear exactly in the ISSUE cycle
          if (|(req_wt_i & w_arb_grant)) begin
            wt_req_d             = w_arb_grant;
            tx_data_d[w_arb_idx] = w_wdata[w_arb_idx];
          end else begin
            rd_req_d = w_arb_grant;
          end
          ptr_d = (w_arb_idx == IDX_W'(EP_NUM - 1)) ? '0 : w_arb_idx + 1'b1;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (w_ready_hit) begin
          state_d = ST_RESP;
          ack_d   = grant_q;
          if (!dir_wt_q) begin
            rdata_d = w_rx_data[idx_q];
          end
        end else if (cnt_q == TO_W'(TIMEOUT - 2)) begin
          // The counter is about to reach TIMEOUT-1: ack lands exactly
          // TIMEOUT cycles after the ISSUE cycle
          state_d   = ST_RESP;
          ack_d     = grant_q;
          ack_err_d = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge hclk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      idx_q     <= '0;
      dir_wt_q  <= 1'b0;
      cnt_q     <= '0;
      ack_q     <= '0;
      ack_err_q <= 1'b0;
      rdata_q   <= '0;
      wt_req_q  <= '0;
      rd_req_q  <= '0;
      busy_q    <= 1'b0;
      tx_data_q <= '{default: '0};
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      dir_wt_q  <= dir_wt_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      ack_err_q <= ack_err_d;
      rdata_q   <= rdata_d;
      wt_req_q  <= wt_req_d;
      rd_req_q  <= rd_req_d;
      busy_q    <= busy_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign ack_o            = ack_q;
  assign ack_err_o        = ack_err_q;
  assign rdata_o          = rdata_q;
  assign ep_data_wt_req_o = wt_req_q;
  assign ep_data_rd_req_o = rd_req_q;
  assign busy_o           = busy_q;

endmodule : usbf_mem_req_arb
`default_nettype wire

// File: tb/tb_usbf_mem_req_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_usbf_mem_req_arb
// Description : Self-checking bench for usbf_mem_req_arb. A transaction
//               model tracks grant time, issue time and completion time of
//               each access and predicts every output; directed scenarios
//               add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usbf_mem_req_arb;

  localparam int EPN        = 4;
  localparam int DW         = 32;
  localparam int TB_TIMEOUT = 200;

  logic               clk = 1'b0;
  logic               rst;
  logic [EPN-1:0]     req_wt, req_rd;
  logic [EPN*DW-1:0]  req_wdata, ep_rx_data;
  logic               mem_wt_ready, mem_rd_ready;
  logic [EPN-1:0]     ack, wt_req, rd_req;
  logic               ack_err, busy;
  logic [DW-1:0]      rdata;
  logic [EPN*DW-1:0]  tx;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  initial forever #5 clk = ~clk;

  usbf_mem_req_arb #(
    .EP_NUM  (EPN),
    .DATA_W  (DW),
    .TIMEOUT (TB_TIMEOUT),
    .TO_W    (8)
  ) dut (
    .hclk_i           (clk),
    .rst_i            (rst),
    .req_wt_i         (req_wt),
    .req_rd_i         (req_rd),
    .req_wdata_i      (req_wdata),
    .ack_o            (ack),
    .ack_err_o        (ack_err),
    .rdata_o          (rdata),
    .ep_data_wt_req_o (wt_req),
    .ep_data_rd_req_o (rd_req),
    .ep_tx_data_o     (tx),
    .ep_rx_data_i     (ep_rx_data),
    .mem_wt_ready_i   (mem_wt_ready),
    .mem_rd_ready_i   (mem_rd_ready),
    .busy_o           (busy)
  );

  task automatic chk(input string name, input logic [EPN*DW-1:0] act,
                     input logic [EPN*DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction model ----------------
  bit                m_valid  = 0;
  bit                m_active = 0;
  int                m_ptr, m_ep, m_issue, m_ack_cyc;
  bit                m_wt;
  logic [EPN-1:0]    e_ack, e_wtreq, e_rdreq;
  logic              e_err, e_busy;
  logic [DW-1:0]     e_rdata;
  logic [EPN*DW-1:0] e_tx;

  task automatic model_step();
    cyc++;
    if (rst) begin
      m_valid  = 1;
      m_active = 0;
      m_ptr    = 0;
      e_ack = '0; e_err = 0; e_wtreq = '0; e_rdreq = '0;
      e_busy = 0; e_rdata = '0; e_tx = '0;
    end else begin
      e_ack = '0; e_err = 0; e_wtreq = '0; e_rdreq = '0;
      if (m_active) begin
        if (m_ack_cyc >= 0) begin
          m_active = 0;                       // cycle after ack is idle
        end else if (cyc - 1 > m_issue) begin // previous cycle was waiting
          if (m_wt ? mem_wt_ready : mem_rd_ready) begin
            e_ack[m_ep] = 1'b1;
            m_ack_cyc   = cyc;
            if (!m_wt) e_rdata = ep_rx_data[m_ep*DW +: DW];
          end else if (cyc == m_issue + TB_TIMEOUT) begin
            e_ack[m_ep] = 1'b1;
            e_err       = 1'b1;
            m_ack_cyc   = cyc;
          end
        end
      end else begin
        for (int k = 0; k < EPN; k++) begin
          int c;
          c = (m_ptr + k) % EPN;
          if (!m_active && (req_wt[c] || req_rd[c])) begin
            m_active  = 1;
            m_ep      = c;
            m_wt      = req_wt[c];
            m_issue   = cyc;
            m_ack_cyc = -1;
            m_ptr     = (c + 1) % EPN;
            if (m_wt) begin
              e_wtreq[c] = 1'b1;
              e_tx[c*DW +: DW] = req_wdata[c*DW +: DW];
            end else begin
              e_rdreq[c] = 1'b1;
            end
          end
        end
      end
      e_busy = m_active;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("ack_o", ack, e_ack);
      chk("ack_err_o", ack_err, e_err);
      chk("rdata_o", rdata, e_rdata);
      chk("ep_data_wt_req_o", wt_req, e_wtreq);
      chk("ep_data_rd_req_o", rd_req, e_rdreq);
      chk("ep_tx_data_o", tx, e_tx);
      chk("busy_o", busy, e_busy);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ready(input bit wt);
    if (wt) mem_wt_ready = 1'b1;
    else    mem_rd_ready = 1'b1;
    tick();
    mem_wt_ready = 1'b0;
    mem_rd_ready = 1'b0;
  endtask

  task automatic wait_pulse(output logic [EPN-1:0] w, output logic [EPN-1:0] r);
    bit got;
    got = 0; w = '0; r = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if ((wt_req | rd_req) != '0) begin
        got = 1; w = wt_req; r = rd_req;
      end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL req_pulse_wait: actual=none required=pulse within 20 cycles");
    end
  endtask

  task automatic wait_ack(input int budget, output logic [EPN-1:0] a,
                          output logic err, output int at);
    bit got;
    got = 0; a = '0; err = 0; at = 0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (ack != '0) begin
        got = 1; a = ack; err = ack_err; at = cyc;
      end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL ack_wait: actual=none required=ack within %0d cycles", budget);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_watchdog: actual=no finish required=finish");
    $fatal(1, "bench watchdog expired");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [EPN-1:0] w, r, a;
    logic           err;
    int             at, t_issue;
    int             exp_ord [5];
    exp_ord = '{0, 1, 2, 3, 0};

    rst = 1; req_wt = '0; req_rd = '0; req_wdata = '0; ep_rx_data = '0;
    mem_wt_ready = 0; mem_rd_ready = 0;
    tick(); tick();
    rst = 0;
    chk("reset_busy", busy, 0);
    chk("reset_ack", ack, 0);

    // 1: single write on EP1, ready at cycle 6, ack at cycle 7
    req_wdata[1*DW +: DW] = 32'hA5A5_0001;
    req_wt = 4'b0010;
    tick();
    chk("t1_wt_pulse", wt_req, 4'b0010);
    tick();
    chk("t1_pulse_one_cycle", wt_req, 4'b0000);
    req_wdata[1*DW +: DW] = 32'hDEAD_BEEF;
    tick(); tick(); tick(); tick();
    mem_wt_ready = 1;
    tick();
    mem_wt_ready = 0;
    chk("t1_ack", ack, 4'b0010);
    chk("t1_ack_err", ack_err, 0);
    chk("t1_tx_slice1", tx[1*DW +: DW], 32'hA5A5_0001);
    req_wt = '0;

    // 2: read on EP2, rdata held through a following write
    tick();
    req_rd = 4'b0100;
    ep_rx_data[2*DW +: DW] = 32'h1234_5678;
    wait_pulse(w, r);
    chk("t2_rd_pulse", r, 4'b0100);
    tick(); tick();
    pulse_ready(0);
    chk("t2_ack", ack, 4'b0100);
    chk("t2_rdata", rdata, 32'h1234_5678);
    req_rd = '0;
    ep_rx_data[2*DW +: DW] = '0;
    req_wt = 4'b0001;
    req_wdata[0 +: DW] = 32'h0000_0E00;
    wait_pulse(w, r);
    chk("t2_wt_pulse", w, 4'b0001);
    tick();
    pulse_ready(1);
    chk("t2_wt_ack", ack, 4'b0001);
    req_wt = '0;
    chk("t2_rdata_held", rdata, 32'h1234_5678);

    // 3: round-robin from a fresh pointer, EP0 re-requests while EP1 served
    rst = 1;
    tick();
    rst = 0;
    for (int e = 0; e < EPN; e++) req_wdata[e*DW +: DW] = 32'h3000_0000 + e;
    req_wt = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_pulse(w, r);
      chk("t3_rr_grant", w, 4'b0001 << exp_ord[g]);
      if (g == 1) req_wt[0] = 1'b1;
      tick();
      pulse_ready(1);
      chk("t3_rr_ack", ack, 4'b0001 << exp_ord[g]);
      req_wt = req_wt & ~w;
    end

    // 4: write+read on EP1, write first, wrong-direction ready ignored
    tick();
    req_wdata[1*DW +: DW] = 32'h4444_0001;
    req_wt = 4'b0010;
    req_rd = 4'b0010;
    wait_pulse(w, r);
    chk("t4_wt_first", w, 4'b0010);
    chk("t4_no_rd_yet", r, 4'b0000);
    tick();
    pulse_ready(0);
    chk("t4_wrong_dir_ignored", ack, 4'b0000);
    pulse_ready(1);
    chk("t4_wt_ack", ack, 4'b0010);
    req_wt = '0;
    ep_rx_data[1*DW +: DW] = 32'hCAFE_F00D;
    wait_pulse(w, r);
    chk("t4_rd_next", r, 4'b0010);
    tick();
    pulse_ready(0);
    chk("t4_rd_ack", ack, 4'b0010);
    chk("t4_rdata", rdata, 32'hCAFE_F00D);
    req_rd = '0;

    // 5: timeout on EP3 write, then a late ready in IDLE
    tick();
    req_wdata[3*DW +: DW] = 32'h5555_0003;
    req_wt = 4'b1000;
    wait_pulse(w, r);
    t_issue = cyc;
    wait_ack(400, a, err, at);
    chk("t5_timeout_latency", at - t_issue, TB_TIMEOUT);
    chk("t5_ack", a, 4'b1000);
    chk("t5_ack_err", err, 1);
    req_wt = '0;
    tick();
    pulse_ready(1);
    chk("t5_late_ready_no_ack", ack, 0);
    tick();
    chk("t5_late_ready_no_ack2", ack, 0);
    chk("t5_idle", busy, 0);

    // 6: reset in WAIT, requests held, re-arbitration from EP0
    tick();
    req_wt = 4'b0010;
    wait_pulse(w, r);
    chk("t6_first_grant", w, 4'b0010);
    tick(); tick();
    req_wdata[2*DW +: DW] = 32'h6666_0002;
    req_wt = 4'b0110;
    req_rd = 4'b0001;
    rst = 1;
    tick();
    rst = 0;
    mem_wt_ready = 1;
    chk("t6_busy", busy, 0);
    chk("t6_ack", ack, 0);
    chk("t6_tx", tx, 0);
    chk("t6_rdata", rdata, 0);
    tick();
    mem_wt_ready = 0;
    chk("t6_rearb_ep0_rd", rd_req, 4'b0001);
    chk("t6_rearb_no_wt", wt_req, 4'b0000);
    tick();
    pulse_ready(0);
    chk("t6_rd_ack", ack, 4'b0001);
    req_wt = '0;
    req_rd = '0;
    tick(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_usbf_mem_req_arb
`default_nettype wire
